// File: rtl/quad_encoder_velocity.sv
// Quadrature encoder front end: pin synchronisers, glitch filter, 4x decode,
// signed position (wrap or clamp) and windowed signed velocity with strobe.
module quad_encoder_velocity #(
    parameter int POS_W       = 16,
    parameter int VEL_W       = 12,
    parameter int WINDOW      = 50000,
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_LEN  = 4,
    parameter int SATURATE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_a,
    input  logic             input_b,
    input  logic             clear,
    input  logic             error_clear,
    output logic [POS_W-1:0] pos_count,
    output logic [VEL_W-1:0] velocity,
    output logic             vel_valid,
    output logic             direction,
    output logic             step_error
);

    localparam int CNT_W  = $clog2(FILTER_LEN + 1);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam int WIN_W  = $clog2(WINDOW);

    localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             sync_ab;

    logic [FILL_W-1:0] fill_cnt;
    logic [1:0]        last_ab;
    logic [CNT_W-1:0]  run_cnt;
    logic [1:0]        filt_ab;
    logic [1:0]        prev_ab;
    logic              filt_chg;
    logic              baseline;

    logic              step_fwd;
    logic              step_rev;
    logic              step_bad;
    logic [1:0]        quad_delta;
    logic [POS_W-1:0]  pos_next;
    logic [VEL_W-1:0]  acc;
    logic [VEL_W-1:0]  acc_sum;
    logic [WIN_W-1:0]  win_cnt;

    // Position of an {A,B} state along the forward cycle 00->10->11->01.
    function automatic logic [1:0] quad_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   quad_idx = 2'd0;
            2'b10:   quad_idx = 2'd1;
            2'b11:   quad_idx = 2'd2;
            default: quad_idx = 2'd3;
        endcase
    endfunction

    assign sync_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    // NOTE: the synchroniser flops are reset too, so the filter never sees X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], input_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], input_b};
        end
    end

    // Filtering starts only once the synchroniser holds real pin samples;
    // run_cnt counts consecutive identical samples ending with last_ab.
    // NOTE: non-blocking assignments so every flop here sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_cnt <= '0;
            last_ab  <= '0;
            run_cnt  <= '0;
            filt_ab  <= '0;
            prev_ab  <= '0;
            filt_chg <= 1'b0;
            baseline <= 1'b0;
        end else begin
            filt_chg <= 1'b0;
            last_ab  <= sync_ab;
            if (fill_cnt != FILL_W'(SYNC_STAGES)) begin
                fill_cnt <= fill_cnt + FILL_W'(1);
                run_cnt  <= '0;
            end else begin
                if (sync_ab != last_ab)
                    run_cnt <= CNT_W'(1);
                else if (run_cnt != CNT_W'(FILTER_LEN))
                    run_cnt <= run_cnt + CNT_W'(1);

                if (run_cnt == CNT_W'(FILTER_LEN) && (!baseline || last_ab != filt_ab)) begin
                    filt_ab  <= last_ab;
                    prev_ab  <= filt_ab;
                    baseline <= 1'b1;
                    filt_chg <= baseline;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        step_fwd   = 1'b0;
        step_rev   = 1'b0;
        step_bad   = 1'b0;
        quad_delta = quad_idx(filt_ab) - quad_idx(prev_ab);
        if (filt_chg) begin
            case (quad_delta)
                2'd1:    step_fwd = 1'b1;
                2'd3:    step_rev = 1'b1;
                2'd2:    step_bad = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        pos_next = pos_count;
        if (clear)
            pos_next = '0;
        else if (step_fwd && !(SATURATE != 0 && pos_count == POS_MAX))
            pos_next = pos_count + POS_W'(1);
        else if (step_rev && !(SATURATE != 0 && pos_count == POS_MIN))
            pos_next = pos_count - POS_W'(1);
    end

    always_comb begin
        acc_sum = acc;
        if (step_fwd && acc != VEL_MAX)
            acc_sum = acc + VEL_W'(1);
        else if (step_rev && acc != VEL_MIN)
            acc_sum = acc - VEL_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_count  <= '0;
            direction  <= 1'b0;
            step_error <= 1'b0;
        end else begin
            pos_count <= pos_next;
            if (step_fwd)
                direction <= 1'b1;
            else if (step_rev)
                direction <= 1'b0;
            if (step_bad)
                step_error <= 1'b1;
            else if (error_clear)
                step_error <= 1'b0;
        end
    end

    // vel_valid is registered alongside velocity, so the strobe marks the
    // cycle in which the new window result is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt   <= '0;
            acc       <= '0;
            velocity  <= '0;
            vel_valid <= 1'b0;
        end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
            win_cnt   <= '0;
            acc       <= '0;
            velocity  <= acc_sum;
            vel_valid <= 1'b1;
        end else begin
            win_cnt   <= win_cnt + WIN_W'(1);
            acc       <= acc_sum;
            vel_valid <= 1'b0;
        end
    end

endmodule
